subleq_mem_resp: RTL and testbench

// - Memory responder for the SUBLEQ core bus: word-addressed RAM, program loader, memory-mapped output FIFO.
// - Loads a program from a byte stream while holding the core off, then releases cpu_en to run it.
// - Serves the core's combinational-read / clocked-write bus and traps stores to IO_ADDR into an output FIFO.

---
 rtl/subleq_mem_resp.sv | 242 ++++++++++++++++++++++++
 tb/tb_subleq_mem_resp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : subleq_mem_resp
// Purpose  : Memory responder for the SUBLEQ core bus. It provides a
//            word-addressed RAM, a byte-stream program loader that holds the
//            core off until the program is in RAM, and a memory-mapped output
//            FIFO behind IO_ADDR.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            ld_valid/ld_ready/ld_byte/ld_last - program byte stream (LE words)
//            cpu_en                    - core enable, high only while running
//            mem_we/mem_addr/mem_data  - core bus; reads are combinational,
//                                        writes commit on posedge clk
//            out_valid/out_ready/out_data - output FIFO head
//            out_ovf                   - sticky: an IO store hit a full FIFO
// Options  : SUBLEQ_MEM_CLEAR_EN - when defined, RAM is swept to zero after
//            every reset (one word per cycle) before the loader is ready.
// Revision : 1.0 - initial release
// ============================================================================
module subleq_mem_resp #(
  parameter int          ADDR_W    = 10,
  parameter int          OUT_DEPTH = 4,
  parameter logic [31:0] IO_ADDR   = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        cpu_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  localparam int c_words = 2 ** ADDR_W;
  localparam int c_pw    = $clog2(OUT_DEPTH);
  localparam int c_cnt_w = c_pw + 1;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Loader
  logic [ADDR_W-1:0]   r_ptr;
  logic [1:0]          r_cnt;
  logic [23:0]         r_asm;
  logic                w_ld_fire;
  logic                w_ld_commit;
  logic [31:0]         w_ld_word;

  // RAM
  logic [31:0]         r_mem [0:c_words-1];
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [31:0]         w_mem_wdata;
  logic [ADDR_W-1:0]   w_core_idx;
  logic                w_io_hit;
  logic [31:0]         w_rd_data;

  // Output FIFO
  logic [31:0]         r_fifo [0:OUT_DEPTH-1];
  logic [c_pw-1:0]     r_rd_ptr;
  logic [c_pw-1:0]     r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_ovf;
  logic                w_full;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;

  logic                w_clr_busy;

`ifdef SUBLEQ_MEM_CLEAR_EN
  logic                r_clr_busy;
  logic [ADDR_W-1:0]   r_clr_addr;

  // Sweep runs for exactly c_words cycles after the last reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_busy <= 1'b1;
      r_clr_addr <= '0;
    end else if (r_clr_busy) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (&r_clr_addr) begin
        r_clr_busy <= 1'b0;
      end
    end
  end

  assign w_clr_busy = r_clr_busy;
`else
  assign w_clr_busy = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  assign w_ld_fire   = ld_valid && (r_state == ST_LOAD) && !w_clr_busy;
  assign w_ld_commit = w_ld_fire && ((r_cnt == 2'd3) || ld_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cpu_en      = 1'b0;
    ld_ready    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        ld_ready = !w_clr_busy;
        if (w_ld_fire && ld_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_en = 1'b1;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Loader: bytes 0..2 are staged in r_asm; the 4th byte (or a last byte)
  // completes the word, which is written straight from the bus byte. Bytes
  // above the current position are zero because r_asm is cleared per word.
  // --------------------------------------------------------------------------
  assign w_ld_word = {8'h00, r_asm} | ({24'h0, ld_byte} << {r_cnt, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= 2'd0;
      r_asm <= 24'h0;
    end else if (w_ld_fire) begin
      if (w_ld_commit) begin
        r_ptr <= r_ptr + 1'b1;
        r_cnt <= 2'd0;
        r_asm <= 24'h0;
      end else begin
        r_asm[8*r_cnt +: 8] <= ld_byte;
        r_cnt               <= r_cnt + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM write port: clear sweep, loader and core never overlap in time.
  // --------------------------------------------------------------------------
  assign w_io_hit   = (mem_addr == IO_ADDR);
  assign w_core_idx = mem_addr[ADDR_W+1:2];

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = 32'h0;
`ifdef SUBLEQ_MEM_CLEAR_EN
    if (r_clr_busy) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_addr;
    end else
`endif
    if (w_ld_commit) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_ptr;
      w_mem_wdata = w_ld_word;
    end else if (cpu_en && mem_we && !w_io_hit) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_core_idx;
      w_mem_wdata = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Combinational read; the bus is only driven when the core is reading.
  assign w_rd_data = w_io_hit ? {30'h0, r_ovf, !w_full} : r_mem[w_core_idx];
  assign mem_data  = (cpu_en && !mem_we) ? w_rd_data : 32'bz;

  // --------------------------------------------------------------------------
  // Output FIFO. A push on a full FIFO is still accepted if a pop frees the
  // head slot on the same edge.
  // --------------------------------------------------------------------------
  assign w_full     = (r_count == c_cnt_w'(OUT_DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_push_req = cpu_en && mem_we && w_io_hit;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign out_data   = out_valid ? r_fifo[r_rd_ptr] : 32'h0;
  assign out_ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wr_ptr] <= mem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subleq_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_subleq_mem_resp
// Purpose  : Self-checking bench for subleq_mem_resp. A word-array RAM model
//            and a FIFO expectation queue are updated as stimulus is issued;
//            a negedge monitor pops the queue whenever the DUT pops its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subleq_mem_resp;

  localparam int          ADDR_W    = 4;
  localparam int          OUT_DEPTH = 4;
  localparam int          WORDS     = 16;
  localparam logic [31:0] IO_ADDR   = 32'hFFFF_FFFC;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        ld_valid  = 1'b0;
  logic [7:0]  ld_byte   = 8'h0;
  logic        ld_last   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic        out_ready = 1'b0;
  wire         ld_ready;
  wire         cpu_en;
  wire  [31:0] mem_data;
  wire         out_valid;
  wire  [31:0] out_data;
  wire         out_ovf;

  assign mem_data = mem_we ? wdata : 32'bz;

  subleq_mem_resp #(
    .ADDR_W    (ADDR_W),
    .OUT_DEPTH (OUT_DEPTH),
    .IO_ADDR   (IO_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .cpu_en    (cpu_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] mem_m   [WORDS];
  bit          known_m [WORDS];
  logic [31:0] exp_q   [$];
  bit          ovf_m;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == IO_ADDR) return {30'h0, ovf_m, (exp_q.size() < OUT_DEPTH)};
    return mem_m[a[5:2]];
  endfunction

  // Called after the edge that commits the store; any same-cycle pop has
  // already been taken off the queue by the monitor.
  task automatic model_io_push(input logic [31:0] d);
    if (exp_q.size() < OUT_DEPTH) exp_q.push_back(d);
    else ovf_m = 1'b1;
  endtask

  // Monitor: FIFO flags every cycle, head word on every pop.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("out_ovf", 32'(out_ovf), 32'(ovf_m));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    int n;
    rst       = 1'b1;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    mem_we    = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    ovf_m     = 1'b0;
    step();
    step();
    rst = 1'b0;
`ifdef SUBLEQ_MEM_CLEAR_EN
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i]   = 32'h0;
      known_m[i] = 1'b1;
    end
`endif
    n = 0;
    while (!ld_ready && n < WORDS + 10) begin
      n++;
      step();
    end
`ifdef SUBLEQ_MEM_CLEAR_EN
    chk("ld_ready_low_cycles", 32'(n), 32'(WORDS));
`else
    chk("ld_ready_low_cycles", 32'(n), 32'd0);
`endif
  endtask

  task automatic load_prog(input logic [7:0] b[$], input bit has_last);
    int n;
    logic [31:0] w;
    n = b.size();
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!ld_ready && t < 50) begin
        t++;
        step();
      end
      if (!ld_ready) chk("ld_ready_timeout", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_byte  = b[k];
      ld_last  = has_last && (k == n - 1);
      if (ld_last) chk("cpu_en_before_last", 32'(cpu_en), 32'd0);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    // Word j holds bytes 4j..4j+3; ptr wraps modulo the RAM size.
    for (int j = 0; 4 * j < n; j++) begin
      if ((4 * j + 3 < n) || has_last) begin
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (4 * j + i < n) w = w | (32'(b[4*j+i]) << (8 * i));
        end
        mem_m[j % WORDS]   = w;
        known_m[j % WORDS] = 1'b1;
      end
    end
    if (has_last) chk("cpu_en_after_last", 32'(cpu_en), 32'd1);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a;
    wdata    = d;
    mem_we   = 1'b1;
    step();
    mem_we   = 1'b0;
    if (a == IO_ADDR) model_io_push(d);
    else begin
      mem_m[a[5:2]]   = d;
      known_m[a[5:2]] = 1'b1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    mem_we   = 1'b0;
    mem_addr = a;
    #1;
    chk(nm, mem_data, exp);
    step();
  endtask

  logic [7:0]  bq [$];
  logic [31:0] a;
  int          idx;
  int          t;

  initial begin
    checks = 0;
    errors = 0;
    ovf_m  = 1'b0;
    for (int i = 0; i < WORDS; i++) known_m[i] = 1'b0;

    // Reset values
    do_reset();
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);

    // Six-byte program with a partial final word
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_prog(bq, 1'b1);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    rd(32'h0, 32'h04030201, "mem0");
    rd(32'h4, 32'h00000605, "mem1");
    cpu_write(32'h8, 32'h0000DEAD);
    rd(32'h8, 32'h0000DEAD, "mem2_wr");
    rd(32'h0000_0045, 32'h00000605, "alias_upper");
    rd(32'h1234_5606, 32'h00000605, "alias_low_bits");

    // FIFO ordering
    out_ready = 1'b0;
    cpu_write(IO_ADDR, 32'd7);
    cpu_write(IO_ADDR, 32'd8);
    cpu_write(IO_ADDR, 32'd9);
    chk("fifo_valid", 32'(out_valid), 32'd1);
    chk("fifo_head7", out_data, 32'd7);
    out_ready = 1'b1;
    step();
    chk("fifo_head8", out_data, 32'd8);
    step();
    chk("fifo_head9", out_data, 32'd9);
    step();
    out_ready = 1'b0;
    chk("fifo_empty", 32'(out_valid), 32'd0);

    // Overflow and full push+pop
    for (int i = 1; i <= 5; i++) cpu_write(IO_ADDR, 32'(i));
    chk("ovf_set", 32'(out_ovf), 32'd1);
    rd(IO_ADDR, 32'h2, "io_status_full");
    out_ready = 1'b1;
    cpu_write(IO_ADDR, 32'd6);
    out_ready = 1'b0;
    rd(IO_ADDR, 32'h2, "io_status_pushpop");
    chk("head_after_pushpop", out_data, 32'd2);
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      t++;
      step();
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    rd(IO_ADDR, 32'h3, "io_status_empty_ovf");

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1: cpu_write(IO_ADDR, $urandom);
        2: begin
          a      = $urandom;
          a[5:2] = 4'($urandom_range(0, WORDS - 1));
          if (a == IO_ADDR) a[31] = 1'b0;
          cpu_write(a, $urandom);
        end
        3: begin
          idx = $urandom_range(0, WORDS - 1);
          a   = $urandom;
          a[5:2] = 4'(idx);
          if (a == IO_ADDR) a[31] = 1'b0;
          if (known_m[idx]) rd(a, model_rd(a), "rand_rd");
          else step();
        end
        default: rd(IO_ADDR, model_rd(IO_ADDR), "rand_io_status");
      endcase
    end
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      t++;
      step();
    end
    chk("rand_drain_done", 32'(exp_q.size()), 32'd0);

    // Reset mid-run with FIFO contents and sticky overflow
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cpu_write(IO_ADDR, 32'(100 + i));
    do_reset();
    chk("midrun_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_out_data", out_data, 32'h0);
    chk("midrun_out_ovf", 32'(out_ovf), 32'd0);

    // Reset mid-load, then a wrapping load of WORDS+1 words
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom_range(0, 255)));
    load_prog(bq, 1'b0);
    chk("midload_cpu_en", 32'(cpu_en), 32'd0);
    do_reset();
    chk("midload_rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midload_rst_ld_ready", 32'(ld_ready), 32'd1);
    bq.delete();
    for (int i = 0; i < 4 * (WORDS + 1); i++) bq.push_back(8'($urandom_range(0, 255)));
    load_prog(bq, 1'b1);
    rd(32'h0, {bq[67], bq[66], bq[65], bq[64]}, "wrap_mem0");
    for (int i = 1; i < WORDS; i++) rd(32'(4 * i), model_rd(32'(4 * i)), "wrap_mem");

`ifdef SUBLEQ_MEM_CLEAR_EN
    do_reset();
    bq = '{8'hAA};
    load_prog(bq, 1'b1);
    rd(32'h0, 32'h000000AA, "clear_mem0");
    for (int i = 1; i < WORDS; i++) rd(32'(4 * i), 32'h0, "clear_mem");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
